// File: rtl/fc_window_data_ram.sv
// FC data buffer: filled sequentially, drained as strided WINDOW-wide windows, one per clock.
// Define FC_RAM_WRAP_EN to wrap lanes past the fill level circularly instead of zero-padding them.
module fc_window_data_ram #(
    parameter int BIT_WIDTH = 16,
    parameter int DEPTH     = 16,
    parameter int WINDOW    = 5,
    parameter int ADDR_W    = $clog2(DEPTH),
    parameter int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        wr_en,
    input  logic [BIT_WIDTH-1:0]        wr_data,
    input  logic                        wr_clear,
    output logic                        wr_ready,
    output logic                        full,
    output logic [CNT_W-1:0]            count,
    input  logic                        rd_start,
    input  logic [ADDR_W-1:0]           rd_base,
    input  logic [ADDR_W-1:0]           rd_stride,
    output logic                        busy,
    output logic                        rd_valid,
    output logic                        rd_last,
    output logic [WINDOW*BIT_WIDTH-1:0] data_out
);
    localparam int PW = CNT_W + 1;

    typedef enum logic {IDLE, SCAN} state_t;

    state_t                      state_q, state_d;
    logic [PW-1:0]               ptr_q, ptr_d;
    logic [ADDR_W-1:0]           stride_q, stride_d;
    logic [CNT_W-1:0]            lim_q, lim_d;
    logic [CNT_W-1:0]            count_q, count_d;
    logic                        rdValid_q, rdValid_d;
    logic                        rdLast_q, rdLast_d;
    logic [WINDOW*BIT_WIDTH-1:0] dataOut_q, dataOut_d;
    logic [WINDOW*BIT_WIDTH-1:0] window;
    logic [BIT_WIDTH-1:0]        ram_q [DEPTH];
    logic [PW-1:0]               laneIdx [WINDOW];
    logic [PW-1:0]               ptrNext, limExt;
    logic                        wrAccept, clearAccept, startAccept;

    assign busy        = (state_q == SCAN);
    assign full        = (count_q == CNT_W'(DEPTH));
    assign wr_ready    = ~busy & ~full;
    assign count       = count_q;
    assign rd_valid    = rdValid_q;
    assign rd_last     = rdLast_q;
    assign data_out    = dataOut_q;

    assign wrAccept    = wr_en & wr_ready;
    assign clearAccept = wr_clear & ~busy;
    assign startAccept = rd_start & (count_q != '0) & (PW'(rd_base) < PW'(count_q));
    assign limExt      = PW'(lim_q);
    assign ptrNext     = ptr_q + PW'(stride_q);

    // A clear in the same cycle as an accepted write discards the write.
    always_comb begin
        count_d = count_q;
        if (clearAccept) begin
            count_d = '0;
        end else if (wrAccept) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (wrAccept && !clearAccept) begin
            ram_q[count_q[ADDR_W-1:0]] <= wr_data;
        end
    end

    // Lanes are bounded by the fill level captured at scan start, not by DEPTH.
    always_comb begin
        window = '0;
        for (int k = 0; k < WINDOW; k++) begin
            laneIdx[k] = ptr_q + PW'(k);
`ifdef FC_RAM_WRAP_EN
            if (lim_q != '0) begin
                laneIdx[k] = laneIdx[k] % limExt;
                window[k*BIT_WIDTH +: BIT_WIDTH] = ram_q[laneIdx[k][ADDR_W-1:0]];
            end
`else
            if (laneIdx[k] < limExt) begin
                window[k*BIT_WIDTH +: BIT_WIDTH] = ram_q[laneIdx[k][ADDR_W-1:0]];
            end
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        stride_d  = stride_q;
        lim_d     = lim_q;
        dataOut_d = dataOut_q;
        rdValid_d = 1'b0;
        rdLast_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (startAccept) begin
                    state_d  = SCAN;
                    ptr_d    = PW'(rd_base);
                    stride_d = (rd_stride == '0) ? ADDR_W'(1) : rd_stride;
                    lim_d    = count_q;
                end
            end
            SCAN: begin
                dataOut_d = window;
                rdValid_d = 1'b1;
                rdLast_d  = (ptrNext >= limExt);
                ptr_d     = ptrNext;
                if (ptrNext >= limExt) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            stride_q  <= '0;
            lim_q     <= '0;
            count_q   <= '0;
            rdValid_q <= 1'b0;
            rdLast_q  <= 1'b0;
            dataOut_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            stride_q  <= stride_d;
            lim_q     <= lim_d;
            count_q   <= count_d;
            rdValid_q <= rdValid_d;
            rdLast_q  <= rdLast_d;
            dataOut_q <= dataOut_d;
        end
    end

endmodule

// File: tb/tb_fc_window_data_ram.sv
// Directed bench for fc_window_data_ram: fill, strided scans, ignored requests, reset mid-scan.
// Expected windows follow FC_RAM_WRAP_EN when it is defined for the build.
module tb_fc_window_data_ram;
    localparam int BW = 16;
    localparam int WW = 5 * BW;

    logic          CLK, RST, wr_en, wr_clear, rd_start;
    logic [15:0]   wr_data;
    logic [3:0]    rd_base, rd_stride;
    logic          wr_ready, full, busy, rd_valid, rd_last;
    logic [4:0]    count;
    logic [WW-1:0] data_out;
    logic [WW-1:0] expWin [4];

    int testsRun    = 0;
    int testsFailed = 0;

    fc_window_data_ram #(.BIT_WIDTH(16), .DEPTH(16), .WINDOW(5)) dut (
        .CLK(CLK), .RST(RST),
        .wr_en(wr_en), .wr_data(wr_data), .wr_clear(wr_clear),
        .wr_ready(wr_ready), .full(full), .count(count),
        .rd_start(rd_start), .rd_base(rd_base), .rd_stride(rd_stride),
        .busy(busy), .rd_valid(rd_valid), .rd_last(rd_last), .data_out(data_out)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [WW-1:0] win5(input logic [15:0] l0, l1, l2, l3, l4);
        return {l4, l3, l2, l1, l0};
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic writeWord(input logic [15:0] d);
        wr_en = 1'b1;
        wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic clearCount();
        wr_clear = 1'b1;
        step();
        wr_clear = 1'b0;
    endtask

    task automatic startScan(input logic [3:0] base, input logic [3:0] stride);
        rd_start = 1'b1;
        rd_base = base;
        rd_stride = stride;
        step();
        rd_start = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        step();
        testsRun++; if ({wr_ready, full, count, busy, rd_valid, rd_last} !== {1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0}) begin testsFailed++; $display("[TB] FAIL reset_flags: got %b expected %b", {wr_ready, full, count, busy, rd_valid, rd_last}, {1'b1, 1'b0, 5'd0, 3'b000}); end
        testsRun++; if (data_out !== '0) begin testsFailed++; $display("[TB] FAIL reset_data: got %h expected 0", data_out); end
        RST = 1'b0;
        step();
    endtask

    task automatic test_fill_scan();
        for (int i = 1; i <= 16; i++) writeWord(16'(i));
        testsRun++; if (count !== 5'd16) begin testsFailed++; $display("[TB] FAIL fill_count: got %0d expected 16", count); end
        testsRun++; if (full !== 1'b1) begin testsFailed++; $display("[TB] FAIL fill_full: got %b expected 1", full); end
        testsRun++; if (wr_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL fill_ready: got %b expected 0", wr_ready); end
        writeWord(16'd99);
        testsRun++; if (count !== 5'd16) begin testsFailed++; $display("[TB] FAIL overflow_count: got %0d expected 16", count); end
        expWin[0] = win5(1, 2, 3, 4, 5);
        expWin[1] = win5(6, 7, 8, 9, 10);
        expWin[2] = win5(11, 12, 13, 14, 15);
`ifdef FC_RAM_WRAP_EN
        expWin[3] = win5(16, 1, 2, 3, 4);
`else
        expWin[3] = win5(16, 0, 0, 0, 0);
`endif
        startScan(4'd0, 4'd5);
        testsRun++; if (busy !== 1'b1) begin testsFailed++; $display("[TB] FAIL scan1_busy_start: got %b expected 1", busy); end
        testsRun++; if (rd_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL scan1_latency: got %b expected 0", rd_valid); end
        for (int w = 0; w < 4; w++) begin
            step();
            testsRun++; if (rd_valid !== 1'b1) begin testsFailed++; $display("[TB] FAIL scan1_valid[%0d]: got %b expected 1", w, rd_valid); end
            testsRun++; if (data_out !== expWin[w]) begin testsFailed++; $display("[TB] FAIL scan1_data[%0d]: got %h expected %h", w, data_out, expWin[w]); end
            testsRun++; if (rd_last !== (w == 3)) begin testsFailed++; $display("[TB] FAIL scan1_last[%0d]: got %b expected %b", w, rd_last, w == 3); end
            testsRun++; if (busy !== (w < 3)) begin testsFailed++; $display("[TB] FAIL scan1_busy[%0d]: got %b expected %b", w, busy, w < 3); end
        end
        step();
        testsRun++; if ({rd_valid, rd_last} !== 2'b00) begin testsFailed++; $display("[TB] FAIL scan1_end: got %b expected 00", {rd_valid, rd_last}); end
        testsRun++; if (data_out !== expWin[3]) begin testsFailed++; $display("[TB] FAIL scan1_hold: got %h expected %h", data_out, expWin[3]); end
    endtask

    task automatic test_stride_zero();
        clearCount();
        testsRun++; if (count !== 5'd0) begin testsFailed++; $display("[TB] FAIL clear_count: got %0d expected 0", count); end
        for (int i = 10; i <= 16; i++) writeWord(16'(i));
        testsRun++; if ({count, full, wr_ready} !== {5'd7, 1'b0, 1'b1}) begin testsFailed++; $display("[TB] FAIL fill7_state: got %b expected %b", {count, full, wr_ready}, {5'd7, 2'b01}); end
`ifdef FC_RAM_WRAP_EN
        expWin[0] = win5(14, 15, 16, 10, 11);
        expWin[1] = win5(15, 16, 10, 11, 12);
        expWin[2] = win5(16, 10, 11, 12, 13);
`else
        expWin[0] = win5(14, 15, 16, 0, 0);
        expWin[1] = win5(15, 16, 0, 0, 0);
        expWin[2] = win5(16, 0, 0, 0, 0);
`endif
        startScan(4'd4, 4'd0);
        for (int w = 0; w < 3; w++) begin
            step();
            testsRun++; if (data_out !== expWin[w] || rd_valid !== 1'b1) begin testsFailed++; $display("[TB] FAIL stride0_data[%0d]: got %h valid %b expected %h valid 1", w, data_out, rd_valid, expWin[w]); end
            testsRun++; if (rd_last !== (w == 2)) begin testsFailed++; $display("[TB] FAIL stride0_last[%0d]: got %b expected %b", w, rd_last, w == 2); end
        end
        step();
        testsRun++; if (rd_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL stride0_end: got %b expected 0", rd_valid); end
    endtask

    task automatic test_ignored_during_scan();
`ifdef FC_RAM_WRAP_EN
        expWin[0] = win5(10, 11, 12, 13, 14);
        expWin[1] = win5(13, 14, 15, 16, 10);
        expWin[2] = win5(16, 10, 11, 12, 13);
`else
        expWin[0] = win5(10, 11, 12, 13, 14);
        expWin[1] = win5(13, 14, 15, 16, 0);
        expWin[2] = win5(16, 0, 0, 0, 0);
`endif
        startScan(4'd0, 4'd3);
        wr_en = 1'b1;
        wr_data = 16'h0999;
        wr_clear = 1'b1;
        rd_start = 1'b1;
        rd_base = 4'd1;
        rd_stride = 4'd1;
        testsRun++; if (wr_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL busy_ready: got %b expected 0", wr_ready); end
        for (int w = 0; w < 3; w++) begin
            step();
            testsRun++; if (data_out !== expWin[w] || rd_valid !== 1'b1) begin testsFailed++; $display("[TB] FAIL busy_data[%0d]: got %h valid %b expected %h valid 1", w, data_out, rd_valid, expWin[w]); end
            testsRun++; if ({rd_last, wr_ready} !== {w == 2, w == 2}) begin testsFailed++; $display("[TB] FAIL busy_last_ready[%0d]: got %b expected %b", w, {rd_last, wr_ready}, {w == 2, w == 2}); end
            testsRun++; if (count !== 5'd7) begin testsFailed++; $display("[TB] FAIL busy_count[%0d]: got %0d expected 7", w, count); end
        end
        wr_en = 1'b0;
        wr_clear = 1'b0;
        rd_start = 1'b0;
        step();
        testsRun++; if ({rd_valid, busy, count} !== {2'b00, 5'd7}) begin testsFailed++; $display("[TB] FAIL busy_after: got %b expected %b", {rd_valid, busy, count}, {2'b00, 5'd7}); end
    endtask

    task automatic test_ignored_start();
        clearCount();
        startScan(4'd0, 4'd1);
        for (int c = 0; c < 3; c++) begin
            testsRun++; if ({busy, rd_valid} !== 2'b00) begin testsFailed++; $display("[TB] FAIL empty_start[%0d]: got %b expected 00", c, {busy, rd_valid}); end
            step();
        end
        writeWord(16'd100);
        writeWord(16'd200);
        writeWord(16'd300);
        testsRun++; if (count !== 5'd3) begin testsFailed++; $display("[TB] FAIL count3: got %0d expected 3", count); end
        startScan(4'd3, 4'd1);
        for (int c = 0; c < 3; c++) begin
            testsRun++; if ({busy, rd_valid} !== 2'b00) begin testsFailed++; $display("[TB] FAIL base_ge_count[%0d]: got %b expected 00", c, {busy, rd_valid}); end
            step();
        end
    endtask

    task automatic test_clear_wins();
        writeWord(16'd400);
        writeWord(16'd500);
        testsRun++; if (count !== 5'd5) begin testsFailed++; $display("[TB] FAIL count5: got %0d expected 5", count); end
        wr_clear = 1'b1;
        wr_en = 1'b1;
        wr_data = 16'h1234;
        step();
        wr_clear = 1'b0;
        wr_en = 1'b0;
        testsRun++; if (count !== 5'd0) begin testsFailed++; $display("[TB] FAIL clear_wins_count: got %0d expected 0", count); end
        writeWord(16'h7FFF);
        testsRun++; if (count !== 5'd1) begin testsFailed++; $display("[TB] FAIL write_after_clear: got %0d expected 1", count); end
`ifdef FC_RAM_WRAP_EN
        expWin[0] = win5(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
`else
        expWin[0] = win5(16'h7FFF, 0, 0, 0, 0);
`endif
        startScan(4'd0, 4'd1);
        step();
        testsRun++; if ($signed(data_out[15:0]) !== 16'sd32767) begin testsFailed++; $display("[TB] FAIL lane0_value: got %0d expected 32767", $signed(data_out[15:0])); end
        testsRun++; if (data_out !== expWin[0] || {rd_valid, rd_last} !== 2'b11) begin testsFailed++; $display("[TB] FAIL single_window: got %h vl %b expected %h vl 11", data_out, {rd_valid, rd_last}, expWin[0]); end
        step();
    endtask

    task automatic test_reset_mid_scan();
        clearCount();
        for (int i = 1; i <= 8; i++) writeWord(16'(i));
        startScan(4'd0, 4'd2);
        step();
        testsRun++; if (data_out !== win5(1, 2, 3, 4, 5) || rd_valid !== 1'b1) begin testsFailed++; $display("[TB] FAIL rst_scan_w0: got %h valid %b expected %h valid 1", data_out, rd_valid, win5(1, 2, 3, 4, 5)); end
        step();
        testsRun++; if (data_out !== win5(3, 4, 5, 6, 7) || rd_last !== 1'b0) begin testsFailed++; $display("[TB] FAIL rst_scan_w1: got %h last %b expected %h last 0", data_out, rd_last, win5(3, 4, 5, 6, 7)); end
        step();
        RST = 1'b1;
        #1;
        testsRun++; if ({wr_ready, full, count, busy, rd_valid, rd_last} !== {1'b1, 1'b0, 5'd0, 3'b000}) begin testsFailed++; $display("[TB] FAIL async_reset_flags: got %b expected %b", {wr_ready, full, count, busy, rd_valid, rd_last}, {1'b1, 1'b0, 5'd0, 3'b000}); end
        testsRun++; if (data_out !== '0) begin testsFailed++; $display("[TB] FAIL async_reset_data: got %h expected 0", data_out); end
        step();
        step();
        RST = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step();
            testsRun++; if ({rd_last, rd_valid, busy, count} !== {3'b000, 5'd0}) begin testsFailed++; $display("[TB] FAIL post_reset[%0d]: got %b expected %b", c, {rd_last, rd_valid, busy, count}, {3'b000, 5'd0}); end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 21; i <= 24; i++) writeWord(16'(i));
`ifdef FC_RAM_WRAP_EN
        expWin[0] = win5(21, 22, 23, 24, 21);
        expWin[1] = win5(23, 24, 21, 22, 23);
        expWin[2] = win5(24, 21, 22, 23, 24);
`else
        expWin[0] = win5(21, 22, 23, 24, 0);
        expWin[1] = win5(23, 24, 0, 0, 0);
        expWin[2] = win5(24, 0, 0, 0, 0);
`endif
        startScan(4'd0, 4'd2);
        step();
        testsRun++; if (data_out !== expWin[0] || {rd_valid, rd_last} !== 2'b10) begin testsFailed++; $display("[TB] FAIL b2b_w0: got %h vl %b expected %h vl 10", data_out, {rd_valid, rd_last}, expWin[0]); end
        step();
        testsRun++; if (data_out !== expWin[1] || {rd_valid, rd_last, busy} !== 3'b110) begin testsFailed++; $display("[TB] FAIL b2b_w1: got %h vlb %b expected %h vlb 110", data_out, {rd_valid, rd_last, busy}, expWin[1]); end
        startScan(4'd3, 4'd1);
        testsRun++; if ({busy, rd_valid} !== 2'b10) begin testsFailed++; $display("[TB] FAIL b2b_restart: got %b expected 10", {busy, rd_valid}); end
        step();
        testsRun++; if (data_out !== expWin[2] || {rd_valid, rd_last} !== 2'b11) begin testsFailed++; $display("[TB] FAIL b2b_w2: got %h vl %b expected %h vl 11", data_out, {rd_valid, rd_last}, expWin[2]); end
        step();
        testsRun++; if ({rd_valid, busy} !== 2'b00) begin testsFailed++; $display("[TB] FAIL b2b_end: got %b expected 00", {rd_valid, busy}); end
    endtask

    initial begin
        RST = 1'b1;
        wr_en = 1'b0;
        wr_clear = 1'b0;
        rd_start = 1'b0;
        wr_data = '0;
        rd_base = '0;
        rd_stride = '0;
        test_reset();
        test_fill_scan();
        test_stride_zero();
        test_ignored_during_scan();
        test_ignored_start();
        test_clear_wins();
        test_reset_mid_scan();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
